// File: rtl/uwire_shifter.sv
// uWire serial transmit stage: shifts one WORD_BITS word out MSB-first with a
// divided serial clock, then pulses latch-enable and returns to ready.
module uwire_shifter #(
  parameter int WORD_BITS = 32,
  parameter int CLK_DIV   = 4,
  parameter int LE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] d,
  input  logic                 start,
  output logic                 ready,
  output logic                 uwire_clk,
  output logic                 uwire_data,
  output logic                 uwire_le
);

  localparam int CNT_MAX = (CLK_DIV > LE_CYCLES) ? CLK_DIV : LE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int BIT_W   = $clog2(WORD_BITS) + 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LE_LAST  = CNT_W'(LE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_INIT = BIT_W'(WORD_BITS);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LE_SETUP = 3'd3,
    LE_PULSE = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_s;
  logic [WORD_BITS-1:0] shreg_r;
  logic [WORD_BITS-1:0] shreg_s;

  logic ready_r;
  logic uwire_clk_r;
  logic uwire_data_r;
  logic uwire_le_r;
  logic ready_s;
  logic uwire_clk_s;
  logic uwire_data_s;
  logic uwire_le_s;

  // State, phase counter, bit counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_cnt_r <= BIT_ZERO;
      shreg_r   <= {WORD_BITS{1'b0}};
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shreg_r   <= shreg_s;
    end
  end

  // Next-state and datapath update; cnt_r counts cycles spent in the current phase
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_cnt_s = bit_cnt_r;
    shreg_s   = shreg_r;
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (start) begin
          state_s   = SHIFT_LO;
          bit_cnt_s = BIT_INIT;
          shreg_s   = d;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT_LO: begin
        if (cnt_r == DIV_LAST) begin
          state_s = SHIFT_HI;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      SHIFT_HI: begin
        if (cnt_r == DIV_LAST) begin
          cnt_s     = CNT_ZERO;
          bit_cnt_s = bit_cnt_r - BIT_ONE;
          // The counter ends at zero; the last bit leaves the bus idle for LE setup
          if (bit_cnt_r != BIT_ONE) begin
            state_s = SHIFT_LO;
            shreg_s = shreg_r << 1'b1;
          end else begin
            state_s = LE_SETUP;
            shreg_s = {WORD_BITS{1'b0}};
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      LE_SETUP: begin
        if (cnt_r == DIV_LAST) begin
          state_s = LE_PULSE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      LE_PULSE: begin
        if (cnt_r == LE_LAST) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = CNT_ZERO;
        bit_cnt_s = BIT_ZERO;
        shreg_s   = {WORD_BITS{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the bus pins come straight from flops
  always_comb begin
    ready_s      = 1'b0;
    uwire_clk_s  = 1'b0;
    uwire_data_s = 1'b0;
    uwire_le_s   = 1'b0;
    case (state_s)
      IDLE: begin
        ready_s = 1'b1;
      end
      SHIFT_LO: begin
        uwire_data_s = shreg_s[WORD_BITS-1];
      end
      SHIFT_HI: begin
        uwire_clk_s  = 1'b1;
        uwire_data_s = shreg_s[WORD_BITS-1];
      end
      LE_SETUP: begin
        uwire_data_s = 1'b0;
      end
      LE_PULSE: begin
        uwire_le_s = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Registered bus outputs; reset returns the bus to idle without an LE pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r      <= 1'b1;
      uwire_clk_r  <= 1'b0;
      uwire_data_r <= 1'b0;
      uwire_le_r   <= 1'b0;
    end else begin
      ready_r      <= ready_s;
      uwire_clk_r  <= uwire_clk_s;
      uwire_data_r <= uwire_data_s;
      uwire_le_r   <= uwire_le_s;
    end
  end

  assign ready      = ready_r;
  assign uwire_clk  = uwire_clk_r;
  assign uwire_data = uwire_data_r;
  assign uwire_le   = uwire_le_r;

endmodule
